// File: rtl/backoff_ctl.sv
// Random backoff controller: draws a slot count from an LFSR, waits the IFS,
// then counts slots down while the channel is idle and pulses backoff_done.
module backoff_ctl #(
  parameter int          CNT_W      = 10,
  parameter int          CW_EXP_MAX = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cw_exp,
  input  logic             backoff_start,
  input  logic             backoff_abort,
  input  logic             ch_idle,
  input  logic [13:0]      ifs_time,
  input  logic [9:0]       slot_time,
  input  logic             force_en,
  input  logic [CNT_W-1:0] force_val,
  output logic             backoff_busy,
  output logic             backoff_done,
  output logic [CNT_W-1:0] backoff_cnt,
  output logic [1:0]       backoff_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IFS = 2'd1,
    COUNT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [13:0]      ifs_cnt, ifs_cnt_nxt, ifs_last;
  logic [9:0]       slot_cnt, slot_cnt_nxt, slot_last;
  logic [3:0]       exp_eff;
  logic [CNT_W-1:0] draw_mask, draw_val;

  // A zero timing value behaves as a one-cycle interval.
  assign ifs_last  = (ifs_time == 14'd0) ? 14'd0 : ifs_time - 14'd1;
  assign slot_last = (slot_time == 10'd0) ? 10'd0 : slot_time - 10'd1;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    exp_eff = (int'(cw_exp) > CW_EXP_MAX) ? 4'(CW_EXP_MAX) : cw_exp;
    for (int i = 0; i < CNT_W; i++) begin
      draw_mask[i] = (i < int'(exp_eff));
    end
    draw_val = force_en ? force_val : (lfsr[CNT_W-1:0] & draw_mask);
  end

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ifs_cnt_nxt  = ifs_cnt;
    slot_cnt_nxt = slot_cnt;
    case (state)
      IDLE: begin
        if (backoff_start && !backoff_abort) begin
          cnt_nxt     = draw_val;
          ifs_cnt_nxt = '0;
          state_nxt   = WAIT_IFS;
        end
      end
      WAIT_IFS: begin
        if (!ch_idle) begin
          ifs_cnt_nxt = '0;
        end else if (ifs_cnt >= ifs_last) begin
          ifs_cnt_nxt  = '0;
          slot_cnt_nxt = '0;
          state_nxt    = (cnt == '0) ? DONE : COUNT;
        end else begin
          ifs_cnt_nxt = ifs_cnt + 14'd1;
        end
      end
      COUNT: begin
        if (!ch_idle) begin
          // A busy channel freezes the count and demands a full IFS again.
          ifs_cnt_nxt = '0;
          state_nxt   = WAIT_IFS;
        end else if (slot_cnt >= slot_last) begin
          slot_cnt_nxt = '0;
          cnt_nxt      = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end else begin
          slot_cnt_nxt = slot_cnt + 10'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (backoff_abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= LFSR_SEED;
      ifs_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lfsr     <= lfsr_nxt;
      ifs_cnt  <= ifs_cnt_nxt;
      slot_cnt <= slot_cnt_nxt;
    end
  end

  assign backoff_state = state;
  assign backoff_busy  = (state != IDLE);
  assign backoff_done  = (state == DONE);
  assign backoff_cnt   = cnt;

endmodule
